// File: rtl/mips_fetch_unit.sv
// mips_fetch_unit: PC holder and single-outstanding instruction fetcher.
// Issues word reads, handles redirects, hands words to the core.
module mips_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          COUNT_WIDTH = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   fetch_enable,
  output logic                   imem_req_valid,
  input  logic                   imem_req_ready,
  output logic [31:0]            imem_req_addr,
  input  logic                   imem_resp_valid,
  input  logic [31:0]            imem_resp_data,
  output logic [31:0]            instruction,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic [31:0]            pc_out,
  input  logic                   redirect_valid,
  input  logic [31:0]            redirect_target,
  output logic                   err_misaligned,
  output logic [COUNT_WIDTH-1:0] fetched_count
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  logic [1:0]             state, state_nx;
  logic [31:0]            pc, pc_nx;
  logic                   drop, drop_nx;
  logic [31:0]            instr_q, instr_nx;
  logic [31:0]            pcout_q, pcout_nx;
  logic [COUNT_WIDTH-1:0] count_q, count_nx;
  logic                   err_q;

  logic       redir_ok;
  logic       redir_bad;
  logic [1:0] park_or_req;

  // An aligned redirect is acted on; a misaligned one only raises the error.
  assign redir_ok  = redirect_valid & (redirect_target[1:0] == 2'b00);
  assign redir_bad = redirect_valid & (redirect_target[1:0] != 2'b00);

  // Where to go once the current fetch has finished.
  assign park_or_req = fetch_enable ? S_REQ : S_IDLE;

  // Next-state, PC, drop flag and output-latch computation.
  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    drop_nx  = drop;
    instr_nx = instr_q;
    pcout_nx = pcout_q;
    count_nx = count_q;
    unique case (state)
      S_IDLE: begin
        if (fetch_enable)
          state_nx = S_REQ;
        if (redir_ok)
          pc_nx = redirect_target;
      end
      S_REQ: begin
        // A pending request stays up until accepted.
        if (imem_req_ready) begin
          state_nx = S_WAIT;
          if (redir_ok)
            drop_nx = 1'b1;
        end
        if (redir_ok)
          pc_nx = redirect_target;
      end
      S_WAIT: begin
        if (imem_resp_valid) begin
          if (drop || redir_ok) begin
            drop_nx  = 1'b0;
            state_nx = park_or_req;
          end else begin
            instr_nx = imem_resp_data;
            pcout_nx = pc;
            state_nx = S_HOLD;
          end
        end else if (redir_ok) begin
          drop_nx = 1'b1;
        end
        if (redir_ok)
          pc_nx = redirect_target;
      end
      S_HOLD: begin
        if (instr_ready) begin
          count_nx = count_q + 1'b1;
          pc_nx    = pc + 32'd4;
          state_nx = park_or_req;
        end
        if (redir_ok) begin
          pc_nx    = redirect_target;
          state_nx = park_or_req;
        end
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= S_IDLE;
      pc      <= RESET_PC;
      drop    <= 1'b0;
      instr_q <= 32'h0;
      pcout_q <= 32'h0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_nx;
      pc      <= pc_nx;
      drop    <= drop_nx;
      instr_q <= instr_nx;
      pcout_q <= pcout_nx;
      count_q <= count_nx;
      err_q   <= redir_bad;
    end
  end

  assign imem_req_valid = (state == S_REQ);
  assign imem_req_addr  = pc;
  assign instr_valid    = (state == S_HOLD);
  assign instruction    = instr_q;
  assign pc_out         = pcout_q;
  assign err_misaligned = err_q;
  assign fetched_count  = count_q;

endmodule

// File: tb/tb_mips_fetch_unit.sv
// tb_mips_fetch_unit: directed checks of the fetch unit.
// Two instances: default reset PC and a wrap-around reset PC.
module tb_mips_fetch_unit;

  logic        clock = 1'b0;
  logic        reset, fetch_enable;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic [31:0] instruction;
  logic        instr_valid, instr_ready;
  logic [31:0] pc_out;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        err_misaligned;
  logic [31:0] fetched_count;

  logic        reset2, fe2, req_ready2, resp_valid2, instr_ready2;
  logic [31:0] resp_data2;
  logic        req_valid2, instr_valid2, err2;
  logic [31:0] req_addr2, instruction2, pc_out2, count2;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  mips_fetch_unit #(.RESET_PC(32'h0), .COUNT_WIDTH(32)) dut (
    .clock(clock), .reset(reset), .fetch_enable(fetch_enable),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data), .instruction(instruction),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .pc_out(pc_out), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .err_misaligned(err_misaligned),
    .fetched_count(fetched_count)
  );

  mips_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .COUNT_WIDTH(32)) dut2 (
    .clock(clock), .reset(reset2), .fetch_enable(fe2),
    .imem_req_valid(req_valid2), .imem_req_ready(req_ready2),
    .imem_req_addr(req_addr2), .imem_resp_valid(resp_valid2),
    .imem_resp_data(resp_data2), .instruction(instruction2),
    .instr_valid(instr_valid2), .instr_ready(instr_ready2),
    .pc_out(pc_out2), .redirect_valid(1'b0),
    .redirect_target(32'h0), .err_misaligned(err2),
    .fetched_count(count2)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One fetch through REQ/WAIT/HOLD on the default instance.
  task automatic fetch_one(input logic [31:0] addr, input int dly,
                           input int stall, input logic redir,
                           input logic [31:0] tgt);
    int n;
    logic [31:0] word;
    n = 0;
    word = addr ^ 32'hA5A5_0000;
    while (!imem_req_valid && n < 20) begin
      tick();
      n++;
    end
    check("req_seen", {31'b0, imem_req_valid}, 32'd1);
    check("req_addr", imem_req_addr, addr);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    check("wait_noreq", {31'b0, imem_req_valid}, 32'd0);
    for (int i = 0; i < dly; i++) begin
      tick();
      check("wait_one_out", {31'b0, imem_req_valid}, 32'd0);
    end
    imem_resp_valid = 1'b1;
    imem_resp_data  = word;
    tick();
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    check("hold_valid", {31'b0, instr_valid}, 32'd1);
    check("hold_instr", instruction, word);
    check("hold_pc", pc_out, addr);
    for (int i = 0; i < stall; i++) begin
      tick();
      check("stall_valid", {31'b0, instr_valid}, 32'd1);
      check("stall_instr", instruction, word);
      check("stall_pc", pc_out, addr);
      check("stall_noreq", {31'b0, imem_req_valid}, 32'd0);
    end
    instr_ready     = 1'b1;
    redirect_valid  = redir;
    redirect_target = tgt;
    tick();
    instr_ready     = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = 32'h0;
  endtask

  initial begin
    reset = 1'b1; fetch_enable = 1'b0;
    imem_req_ready = 1'b0; imem_resp_valid = 1'b0;
    imem_resp_data = 32'h0; instr_ready = 1'b0;
    redirect_valid = 1'b0; redirect_target = 32'h0;
    reset2 = 1'b1; fe2 = 1'b0; req_ready2 = 1'b0;
    resp_valid2 = 1'b0; resp_data2 = 32'h0; instr_ready2 = 1'b0;

    tick();
    tick();
    check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    check("rst_req_addr", imem_req_addr, 32'h0);
    check("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
    check("rst_instr", instruction, 32'h0);
    check("rst_pc_out", pc_out, 32'h0);
    check("rst_count", fetched_count, 32'h0);
    check("rst_err", {31'b0, err_misaligned}, 32'd0);
    check("rst2_addr", req_addr2, 32'hFFFF_FFFC);

    reset = 1'b0;
    fetch_enable = 1'b1;
    tick();
    check("lat_req", {31'b0, imem_req_valid}, 32'd1);

    fetch_one(32'h0, 0, 0, 1'b0, 32'h0);
    fetch_one(32'h4, 0, 0, 1'b0, 32'h0);
    fetch_one(32'h8, 0, 0, 1'b0, 32'h0);
    check("count3", fetched_count, 32'd3);

    fetch_one(32'hC, 4, 3, 1'b0, 32'h0);
    check("count4", fetched_count, 32'd4);

    check("pre_redir_addr", imem_req_addr, 32'h10);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_target = 32'h100;
    tick();
    redirect_valid = 1'b0;
    check("redir_wait_noreq", {31'b0, imem_req_valid}, 32'd0);
    imem_resp_valid = 1'b1;
    imem_resp_data = 32'hDEAD_BEEF;
    tick();
    imem_resp_valid = 1'b0;
    check("drop_no_valid", {31'b0, instr_valid}, 32'd0);
    check("drop_req", {31'b0, imem_req_valid}, 32'd1);
    check("drop_addr", imem_req_addr, 32'h100);
    check("drop_count", fetched_count, 32'd4);

    fetch_one(32'h100, 0, 0, 1'b0, 32'h0);
    check("req_104", imem_req_addr, 32'h104);
    redirect_valid = 1'b1;
    redirect_target = 32'h20;
    tick();
    redirect_valid = 1'b0;
    check("req_redir_valid", {31'b0, imem_req_valid}, 32'd1);
    check("req_redir_addr", imem_req_addr, 32'h20);

    fetch_one(32'h20, 0, 0, 1'b1, 32'h400);
    check("hold_redir_count", fetched_count, 32'd6);
    check("hold_redir_req", {31'b0, imem_req_valid}, 32'd1);
    check("hold_redir_addr", imem_req_addr, 32'h400);

    fetch_one(32'h400, 0, 0, 1'b0, 32'h0);
    redirect_valid = 1'b1;
    redirect_target = 32'h102;
    tick();
    redirect_valid = 1'b0;
    check("mis_err", {31'b0, err_misaligned}, 32'd1);
    check("mis_addr", imem_req_addr, 32'h404);
    tick();
    check("mis_err_clr", {31'b0, err_misaligned}, 32'd0);
    fetch_one(32'h404, 0, 0, 1'b0, 32'h0);
    check("mis_count", fetched_count, 32'd8);

    fetch_enable = 1'b0;
    fetch_one(32'h408, 1, 1, 1'b0, 32'h0);
    check("park_count", fetched_count, 32'd9);
    check("park_noreq", {31'b0, imem_req_valid}, 32'd0);
    tick();
    tick();
    check("park_still", {31'b0, imem_req_valid}, 32'd0);
    check("park_addr", imem_req_addr, 32'h40C);

    reset2 = 1'b0;
    fe2 = 1'b1;
    tick();
    check("w_req", {31'b0, req_valid2}, 32'd1);
    check("w_addr", req_addr2, 32'hFFFF_FFFC);
    req_ready2 = 1'b1;
    tick();
    req_ready2 = 1'b0;
    resp_valid2 = 1'b1;
    resp_data2 = 32'h1234_5678;
    tick();
    resp_valid2 = 1'b0;
    check("w_valid", {31'b0, instr_valid2}, 32'd1);
    check("w_pc", pc_out2, 32'hFFFF_FFFC);
    instr_ready2 = 1'b1;
    tick();
    instr_ready2 = 1'b0;
    check("w_wrap_addr", req_addr2, 32'h0);
    check("w_count", count2, 32'd1);
    req_ready2 = 1'b1;
    tick();
    req_ready2 = 1'b0;
    reset2 = 1'b1;
    tick();
    reset2 = 1'b0;
    fe2 = 1'b0;
    check("w_rst_addr", req_addr2, 32'hFFFF_FFFC);
    check("w_rst_count", count2, 32'd0);
    check("w_rst_instr", instruction2, 32'h0);
    resp_valid2 = 1'b1;
    resp_data2 = 32'hCAFE_F00D;
    tick();
    resp_valid2 = 1'b0;
    check("w_late_valid", {31'b0, instr_valid2}, 32'd0);
    check("w_late_instr", instruction2, 32'h0);
    check("w_late_pc", pc_out2, 32'h0);
    check("w_late_req", {31'b0, req_valid2}, 32'd0);
    check("w_late_err", {31'b0, err2}, 32'd0);
    check("w_late_addr", req_addr2, 32'hFFFF_FFFC);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
